beep_tone_seq: RTL

//   Parametrised tone/burst sequencer for the beeper path; successor of the single-counter

---
 rtl/beep_tone_seq_if.sv | 32 +++
 rtl/beep_tone_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/beep_tone_seq_if.sv
// Beeper sequencer bus: control/config inputs and tone/status outputs.
//   master: drives start, stop, mode, period, high_time, burst_len, gap_len
//           and observes beep, busy, done, err, cnt_now, burst_cnt
//   slave : the sequencer side of the same signals
interface beep_tone_seq_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 16
);
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   high_time;
    logic [BURST_W-1:0] burst_len;
    logic [CNT_W-1:0]   gap_len;
    logic               beep;
    logic               busy;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   cnt_now;
    logic [BURST_W-1:0] burst_cnt;

    modport master (
        output start, stop, mode, period, high_time, burst_len, gap_len,
        input  beep, busy, done, err, cnt_now, burst_cnt
    );

    modport slave (
        input  start, stop, mode, period, high_time, burst_len, gap_len,
        output beep, busy, done, err, cnt_now, burst_cnt
    );
endinterface

// File: rtl/beep_tone_seq.sv
// Tone/burst sequencer for the beeper path. Produces a duty-programmable square
// wave as a one-shot burst, continuously, or as repeating bursts separated by gaps.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : beep_tone_seq_if.slave
//         in : start, stop, mode (00 one-shot, 01 continuous, 10 repeat),
//              period, high_time, burst_len, gap_len
//         out: beep, busy, done (one-shot complete pulse), err (rejected start
//              pulse), cnt_now (period/gap counter), burst_cnt (periods done)
// All outputs are registered.
module beep_tone_seq #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    beep_tone_seq_if.slave  bus
);

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_CONT    = 2'b01;
    localparam logic [1:0] MODE_REPEAT  = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [1:0]         mode_q;
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   high_q;
    logic [BURST_W-1:0] burst_q;
    logic [CNT_W-1:0]   gap_q;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] bcnt_q, bcnt_d;
    logic               beep_q, beep_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               load_cfg;

    logic               cfg_ok;
    logic [CNT_W-1:0]   high_in;
    logic [CNT_W-1:0]   high_sel;
    logic               last_period_clk;
    logic               last_burst_period;
    logic               last_gap_clk;

    // Start validity and clipped high time, evaluated on the raw inputs
    assign cfg_ok  = (bus.period >= CNT_W'(2)) && (bus.mode != MODE_RSVD) &&
                     ((bus.burst_len != '0) || (bus.mode == MODE_CONT));
    assign high_in = (bus.high_time < bus.period) ? bus.high_time : bus.period;

    assign last_period_clk   = (cnt_q == period_q - CNT_W'(1));
    assign last_burst_period = (bcnt_q == burst_q - BURST_W'(1));
    assign last_gap_clk      = (cnt_q == gap_q - CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters and output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load_cfg = 1'b0;
        high_sel = high_q;
        beep_d   = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                bcnt_d = '0;
                if (bus.start) begin
                    if (cfg_ok) begin
                        load_cfg = 1'b1;
                        state_d  = S_TONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_TONE: begin
                if (last_period_clk) begin
                    cnt_d  = '0;
                    bcnt_d = bcnt_q + BURST_W'(1);
                    if ((mode_q != MODE_CONT) && last_burst_period) begin
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = S_IDLE;
                            bcnt_d  = '0;
                            done_d  = 1'b1;
                        end else if (gap_q == '0) begin
                            // zero gap: next burst starts without a silent cycle
                            bcnt_d = '0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (last_gap_clk) begin
                    state_d = S_TONE;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
        endcase

        // Abort overrides everything, including a same-cycle start
        if (bus.stop) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            bcnt_d   = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            load_cfg = 1'b0;
        end

        if (load_cfg) begin
            high_sel = high_in;
        end
        beep_d = (state_d == S_TONE) && (cnt_d < high_sel);
        busy_d = (state_d != S_IDLE);
    end

    // Latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE_ONESHOT;
            period_q <= '0;
            high_q   <= '0;
            burst_q  <= '0;
            gap_q    <= '0;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            beep_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (load_cfg) begin
                mode_q   <= bus.mode;
                period_q <= bus.period;
                high_q   <= high_in;
                burst_q  <= bus.burst_len;
                gap_q    <= bus.gap_len;
            end
            cnt_q  <= cnt_d;
            bcnt_q <= bcnt_d;
            beep_q <= beep_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.beep      = beep_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cnt_now   = cnt_q;
    assign bus.burst_cnt = bcnt_q;

endmodule
